seq_divider_16by8: RTL and testbench
====================================

Name: seq_divider_16by8

Overview:
- Sequential restoring divider; the arithmetic inverse of the team's 8x8 Vedic multiplier.
- Takes a 16-bit dividend and an 8-bit divisor. Produces a 16-bit quotient and an 8-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the datapath and uses a start/busy/done handshake so a controller can issue back-to-back operations.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width.
- DIVISOR_W, 8, divisor and remainder width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > DIVIDEND_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  DIVIDEND_W  numerator, unsigned; captured at the accepting edge.
- divisor  input  DIVISOR_W  denominator, unsigned; captured at the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; quotient/remainder valid.
- quotient  output  DIVIDEND_W  result, unsigned.
- remainder  output  DIVISOR_W  result, unsigned; always < divisor when divisor != 0.
- div_by_zero  output  1  present only with DIV_ZERO_DETECT_EN; qualifies done.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Deassertion is taken synchronously to clk.
- States:
  - IDLE -> CALC on start=1 (accepting edge).
  - CALC -> CALC while counter < DIVIDEND_W-1.
  - CALC -> DONE on the iteration where counter == DIVIDEND_W-1.
  - DONE -> IDLE unconditionally after one cycle.
- Accepting edge: latch dividend into a shift register and divisor into a register; clear the partial remainder (DIVISOR_W+1 bits) and the counter; set busy=1.
- Each CALC edge, one restoring iteration:
  - trial = {prem[DIVISOR_W-1:0], dividend MSB} - {1'b0, divisor}.
  - If trial does not borrow: prem = trial and the shifted-in quotient bit is 1.
  - Otherwise: prem = shifted value and the quotient bit is 0.
  - Dividend register shifts left; counter increments.
- DONE: quotient and remainder registered at the final CALC edge. done=1 and busy=0 for exactly that cycle.
- Latency: done is high in the cycle starting DIVIDEND_W rising edges after the accepting edge (16 for the defaults).
- quotient and remainder hold their values until the next done. Intermediate values are never visible on the output ports.
- start while busy=1, or in the DONE cycle, is ignored; it is not queued.
- A new start in the cycle after done (state IDLE) is accepted, giving a throughput of one op per DIVIDEND_W+2 cycles.
- Operand inputs may change freely after the accepting edge.
- rst asserted mid-operation aborts immediately to reset values; no done pulse is produced.
- Divisor=0 without the feature runs the full latency and yields quotient=all ones, remainder=dividend[DIVISOR_W-1:0]. This falls out of the algorithm; no special logic.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- Defined:
  - div_by_zero port exists.
  - Divisor=0 at the accepting edge goes IDLE -> DONE directly, with done one cycle after acceptance.
  - quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_by_zero=1 with done.
  - div_by_zero=0 on every other done; it holds its value with the results.
- Undefined: port and fast path are absent; behaviour as described in Behaviour.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Default width constants DIV_DIVIDEND_W=16, DIV_DIVISOR_W=8.
- One sub-module is natural: div_restore_step, a combinational single-iteration subtract/compare. It takes prem, the incoming bit and the divisor, and returns the next prem and the quotient bit.
- The top level holds the FSM, counter and registers.

Test Plan:
- 0x03E8 / 0x07 -> done exactly 16 cycles after accept; quotient=0x008E, remainder=0x06, busy high for the 16 cycles before done.
- 0xFFFF / 0xFF -> quotient=0x0101, remainder=0x00. 0x0005 / 0x09 -> quotient=0x0000, remainder=0x05.
- Pulse start again at cycle 5 of an op with different operands -> ignored; first result is unchanged. A start in the cycle after done is accepted.
- 0x1234 / 0x00 -> quotient=0xFFFF, remainder=0x34. With DIV_ZERO_DETECT_EN: done 1 cycle after accept with div_by_zero=1. Without it: done after 16 cycles.
- rst pulsed at cycle 8 of 0x03E8/0x07 -> all outputs 0 immediately and no done. A fresh 0x0064/0x0A after release -> quotient=0x000A, remainder=0x00.
- Random unsigned operands (divisor != 0), 1000 ops -> quotient*divisor+remainder == dividend and remainder < divisor. Check against a reference model, using the 8x8 multiplier for the low product term.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default widths for the sequential divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int DIV_DIVIDEND_W = 16;
    localparam int DIV_DIVISOR_W  = 8;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division iteration (shift in a bit, subtract the divisor if it fits).
module div_restore_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   prem,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   prem_next,
    output logic                 q_bit
);
    logic [DIVISOR_W:0] shifted;
    assign shifted = {prem[DIVISOR_W-1:0], bit_in};
    // A set top bit of prem means the true shifted value exceeds any divisor.
    assign q_bit = prem[DIVISOR_W] | (shifted >= {1'b0, divisor});
    assign prem_next = q_bit ? shifted - {1'b0, divisor} : shifted;
endmodule

// File: rtl/seq_divider_16by8.sv
// seq_divider_16by8: sequential restoring divider, one quotient bit per clock.
// DIV_ZERO_DETECT_EN adds the div_by_zero flag and a one-cycle divide-by-zero path.
module seq_divider_16by8
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic                  div_by_zero
`endif
);
    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W:0]    prem;
    logic [DIVISOR_W:0]    prem_next;
    logic                  q_bit;
    div_restore_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .prem      (prem),
        .bit_in    (dvd[DIVIDEND_W-1]),
        .divisor   (dvs),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );
    // dvd shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            prem      <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dvd  <= dividend;
                    dvs  <= divisor;
                    prem <= '0;
                    cnt  <= '0;
`ifdef DIV_ZERO_DETECT_EN
                    if (divisor == '0) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= '1;
                        remainder   <= dividend[DIVISOR_W-1:0];
                        div_by_zero <= 1'b1;
                    end else begin
                        state <= CALC;
                        busy  <= 1'b1;
                    end
`else
                    state <= CALC;
                    busy  <= 1'b1;
`endif
                end
                CALC: begin
                    dvd  <= {dvd[DIVIDEND_W-2:0], q_bit};
                    prem <= prem_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIVIDEND_W - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= {dvd[DIVIDEND_W-2:0], q_bit};
                        remainder <= prem_next[DIVISOR_W-1:0];
`ifdef DIV_ZERO_DETECT_EN
                        div_by_zero <= 1'b0;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_16by8.sv
// tb_seq_divider_16by8: directed and random checks of seq_divider_16by8 against a scoreboard of expected results.
module tb_seq_divider_16by8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_by_zero;
`endif
    int          total = 0;
    int          bad = 0;
    logic [23:0] sb[$];
    seq_divider_16by8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Issues one operation and waits for its done; inj >= 0 pulses a stray start at that busy cycle.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int inj);
        int          cyc;
        int          lat;
        logic        busy_ok;
        logic [23:0] e;
        lat = 16;
`ifdef DIV_ZERO_DETECT_EN
        if (b == 8'h00) lat = 0;
`endif
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(b == 8'h00 ? {16'hFFFF, a[7:0]} : {a / 16'(b), 8'(a % 16'(b))});
        @(posedge clk);
        cyc = 0;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (done || cyc > 40) break;
            busy_ok &= busy;
            dividend = 16'($urandom);
            divisor  = 8'($urandom_range(255, 1));
            start    = (cyc == inj);
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", cyc, lat);
        if (lat > 0) chk("busy_during_op", busy_ok, 1);
        chk("busy_at_done", busy, 0);
        e = sb.pop_front();
        chk("quotient", quotient, e[23:8]);
        chk("remainder", remainder, e[7:0]);
`ifdef DIV_ZERO_DETECT_EN
        chk("div_by_zero", div_by_zero, b == 8'h00);
`endif
        if (b != 8'h00) begin
            chk("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("rem_lt_div", remainder < b, 1);
        end
    endtask
    initial begin
        logic seen_done;
        logic [15:0] q_hold;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
`ifdef DIV_ZERO_DETECT_EN
        chk("rst_div_by_zero", div_by_zero, 0);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_op(16'h03E8, 8'h07, -1);
        chk("first_quotient_const", quotient, 16'h008E);
        chk("first_remainder_const", remainder, 8'h06);
        run_op(16'hFFFF, 8'hFF, -1);
        run_op(16'h0005, 8'h09, -1);
        run_op(16'h03E8, 8'h07, 5);
        run_op(16'h4321, 8'h13, -1);
        q_hold = quotient;
        dividend = 16'h1111;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("done_cycle_start_ignored", busy, 0);
        chk("result_held", quotient, q_hold);
        chk("done_one_cycle", done, 0);
        run_op(16'h1234, 8'h00, -1);
        @(negedge clk);
        dividend = 16'h03E8;
        divisor  = 8'h07;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_done |= done;
        end
        chk("abort_no_done", seen_done, 0);
        run_op(16'h0064, 8'h0A, -1);
        run_op(16'h0000, 8'h01, -1);
        run_op(16'hFFFF, 8'h01, -1);
        run_op(16'h00FE, 8'hFF, -1);
        for (int i = 0; i < 1000; i++)
            run_op(16'($urandom), 8'($urandom_range(255, 1)), -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
